// File: rtl/rs_dispatch_ctrl.sv
// rs_dispatch_ctrl
// Two-entry decode-to-reservation-station dispatch buffer. Accepts a decode
// pair, then retires the entries in order into the ALU, SFU and AGU
// reservation stations as their free flags allow. Type-11 entries retire
// without writing any RS and pulse `illegal`.
//
// Optional build macro: RS_DISPATCH_PERF_EN adds the stall_cycles and
// disp_count performance counter outputs.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no valid entries; ready for a new decode pair
// ONLY0 | E0 valid, E1 empty (single-slot decode)
// BOTH  | E0 (older) and E1 (younger) both valid
// ONLY1 | E0 retired, E1 still waiting for its RS

module rs_dispatch_ctrl #(
    parameter int PW = 87,
    parameter int CW = 16
) (
    input  logic          clk2,
    input  logic          reset,
    input  logic          flush,
    input  logic [1:0]    dec_valid,
    output logic          dec_ready,
    input  logic [1:0]    dec_type_0,
    input  logic [1:0]    dec_type_1,
    input  logic [PW-1:0] dec_pay_0,
    input  logic [PW-1:0] dec_pay_1,
    input  logic [2:0]    rs_free_1,
    input  logic [2:0]    rs_free_2,
    output logic [2:0]    rs_wr,
    output logic [2:0]    rs_wr_two,
    output logic [2:0]    rs_sel1,
    output logic [PW-1:0] buf_pay_0,
    output logic [PW-1:0] buf_pay_1,
    output logic          illegal
`ifdef RS_DISPATCH_PERF_EN
    ,
    output logic [CW-1:0] stall_cycles,
    output logic [CW-1:0] disp_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONLY0 = 2'd1,
        ST_BOTH  = 2'd2,
        ST_ONLY1 = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_ILL = 2'b11;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_type0;
    logic [1:0]    r_type1;
    logic [PW-1:0] r_pay0;
    logic [PW-1:0] r_pay1;

    logic          w_e0_valid;
    logic          w_e0_disp;
    logic          w_e1_disp;
    logic          w_same;
    logic          w_all_disp;
    logic          w_load;

    // Free flag for a unit type; the illegal type has no RS so reports 0.
    function automatic logic f_free(input logic [2:0] flags, input logic [1:0] t);
        logic res;
        res = 1'b0;
        case (t)
            2'b00:   res = flags[0];
            2'b01:   res = flags[1];
            2'b10:   res = flags[2];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // One-hot RS select for a unit type; the illegal type selects no RS.
    function automatic logic [2:0] f_onehot(input logic [1:0] t);
        logic [2:0] res;
        res = 3'b000;
        case (t)
            2'b00:   res = 3'b001;
            2'b01:   res = 3'b010;
            2'b10:   res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Dispatch decisions and RS write strobes from buffer state and free flags.
    always_comb begin
        w_e0_valid = (r_state == ST_ONLY0) || (r_state == ST_BOTH);
        w_same     = (r_type0 == r_type1);
        w_e0_disp  = 1'b0;
        w_e1_disp  = 1'b0;
        rs_wr      = 3'b000;
        rs_wr_two  = 3'b000;
        rs_sel1    = 3'b000;
        illegal    = 1'b0;

        if (!flush) begin
            w_e0_disp = w_e0_valid && ((r_type0 == TYPE_ILL) || f_free(rs_free_1, r_type0));
            case (r_state)
                ST_ONLY1: w_e1_disp = (r_type1 == TYPE_ILL) || f_free(rs_free_1, r_type1);
                // E1 never overtakes a stalled E0; a same-unit pair needs two slots.
                ST_BOTH:  w_e1_disp = w_e0_disp &&
                                      ((r_type1 == TYPE_ILL) ||
                                       (w_same ? f_free(rs_free_2, r_type1)
                                               : f_free(rs_free_1, r_type1)));
                default:  w_e1_disp = 1'b0;
            endcase
        end

        if (w_e0_disp) begin
            rs_wr = rs_wr | f_onehot(r_type0);
        end
        if (w_e1_disp) begin
            rs_wr = rs_wr | f_onehot(r_type1);
            // Same-unit pair: write_data_1 from E0, write_data_2 from E1.
            if ((r_state == ST_BOTH) && w_same) begin
                rs_wr_two = f_onehot(r_type1);
            end else begin
                rs_sel1 = rs_sel1 | f_onehot(r_type1);
            end
        end

        illegal = (w_e0_disp && (r_type0 == TYPE_ILL)) ||
                  (w_e1_disp && (r_type1 == TYPE_ILL));
    end

    // Buffer drains this cycle when every valid entry dispatches.
    always_comb begin
        w_all_disp = 1'b0;
        case (r_state)
            ST_EMPTY: w_all_disp = 1'b1;
            ST_ONLY0: w_all_disp = w_e0_disp;
            ST_BOTH:  w_all_disp = w_e0_disp && w_e1_disp;
            ST_ONLY1: w_all_disp = w_e1_disp;
            default:  w_all_disp = 1'b0;
        endcase
        dec_ready = !flush && w_all_disp;
        w_load    = dec_ready && dec_valid[0];
    end

    // Next state: flush wins, then a new load, then the drain transitions.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_load) begin
            w_state_nxt = dec_valid[1] ? ST_BOTH : ST_ONLY0;
        end else begin
            case (r_state)
                ST_BOTH: begin
                    if (w_e0_disp && w_e1_disp) w_state_nxt = ST_EMPTY;
                    else if (w_e0_disp)         w_state_nxt = ST_ONLY1;
                end
                ST_ONLY0: if (w_e0_disp) w_state_nxt = ST_EMPTY;
                ST_ONLY1: if (w_e1_disp) w_state_nxt = ST_EMPTY;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entry storage; captured only when a decode pair is accepted.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            r_type0 <= 2'b00;
            r_type1 <= 2'b00;
            r_pay0  <= '0;
            r_pay1  <= '0;
        end else if (w_load) begin
            r_type0 <= dec_type_0;
            r_type1 <= dec_type_1;
            r_pay0  <= dec_pay_0;
            r_pay1  <= dec_pay_1;
        end
    end

    assign buf_pay_0 = r_pay0;
    assign buf_pay_1 = r_pay1;

`ifdef RS_DISPATCH_PERF_EN
    logic [CW-1:0] r_stall_cycles;
    logic [CW-1:0] r_disp_count;
    logic          w_stall;
    logic [CW-1:0] w_disp_inc;

    assign w_stall    = (r_state != ST_EMPTY) && !w_e0_disp && !w_e1_disp;
    assign w_disp_inc = {{(CW-1){1'b0}}, w_e0_disp} + {{(CW-1){1'b0}}, w_e1_disp};

    // Stall counter saturates; dispatch counter wraps.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_disp_count   <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != {CW{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + {{(CW-1){1'b0}}, 1'b1};
            end
            r_disp_count <= r_disp_count + w_disp_inc;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign disp_count   = r_disp_count;
`endif

endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
// Directed bench for rs_dispatch_ctrl. Inputs change and outputs are
// checked just after the falling edge of clk2, away from the rising edge
// that updates the buffer. Counter checks apply when RS_DISPATCH_PERF_EN
// is defined.

module tb_rs_dispatch_ctrl;

    localparam int PW = 87;
    localparam int CW = 16;

    logic          clk2;
    logic          reset;
    logic          flush;
    logic [1:0]    dec_valid;
    logic          dec_ready;
    logic [1:0]    dec_type_0;
    logic [1:0]    dec_type_1;
    logic [PW-1:0] dec_pay_0;
    logic [PW-1:0] dec_pay_1;
    logic [2:0]    rs_free_1;
    logic [2:0]    rs_free_2;
    logic [2:0]    rs_wr;
    logic [2:0]    rs_wr_two;
    logic [2:0]    rs_sel1;
    logic [PW-1:0] buf_pay_0;
    logic [PW-1:0] buf_pay_1;
    logic          illegal;
`ifdef RS_DISPATCH_PERF_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] disp_count;
`endif

    int n_vec;
    int n_miss;

    localparam logic [PW-1:0] PA = {7'h55, 80'h0123_4567_89AB_CDEF_0F1E};
    localparam logic [PW-1:0] PB = {7'h2A, 80'hFEDC_BA98_7654_3210_A5A5};
    localparam logic [PW-1:0] PC = {7'h7F, 80'h1111_2222_3333_4444_5555};
    localparam logic [PW-1:0] PD = {7'h01, 80'hAAAA_BBBB_CCCC_DDDD_EEEE};

    rs_dispatch_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk2       (clk2),
        .reset      (reset),
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_type_0 (dec_type_0),
        .dec_type_1 (dec_type_1),
        .dec_pay_0  (dec_pay_0),
        .dec_pay_1  (dec_pay_1),
        .rs_free_1  (rs_free_1),
        .rs_free_2  (rs_free_2),
        .rs_wr      (rs_wr),
        .rs_wr_two  (rs_wr_two),
        .rs_sel1    (rs_sel1),
        .buf_pay_0  (buf_pay_0),
        .buf_pay_1  (buf_pay_1),
        .illegal    (illegal)
`ifdef RS_DISPATCH_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .disp_count   (disp_count)
`endif
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] wr, input logic [2:0] two,
                           input logic [2:0] sel, input logic ill, input logic rdy);
        chk({tag, ".rs_wr"},     {125'd0, rs_wr},     {125'd0, wr});
        chk({tag, ".rs_wr_two"}, {125'd0, rs_wr_two}, {125'd0, two});
        chk({tag, ".rs_sel1"},   {125'd0, rs_sel1},   {125'd0, sel});
        chk({tag, ".illegal"},   {127'd0, illegal},   {127'd0, ill});
        chk({tag, ".dec_ready"}, {127'd0, dec_ready}, {127'd0, rdy});
    endtask

    task automatic next_slot();
        @(negedge clk2);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] t0, input logic [1:0] t1,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        dec_valid  = v;
        dec_type_0 = t0;
        dec_type_1 = t1;
        dec_pay_0  = p0;
        dec_pay_1  = p1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        rs_free_1 = 3'b111;
        rs_free_2 = 3'b111;

        // Reset state
        #12;
        chk_out("reset", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        chk("reset.buf_pay_0", {41'd0, buf_pay_0}, 128'd0);
        chk("reset.buf_pay_1", {41'd0, buf_pay_1}, 128'd0);
        next_slot();
        reset = 1'b0;

        // ALU + SFU pair, everything free
        drive(2'b11, 2'b00, 2'b01, PA, PB);
        #1;
        chk("alu_sfu.load_ready", {127'd0, dec_ready}, 128'd1);
        next_slot();
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        #1;
        chk_out("alu_sfu", 3'b011, 3'b000, 3'b010, 1'b0, 1'b1);
        chk("alu_sfu.buf_pay_0", {41'd0, buf_pay_0}, {41'd0, PA});
        chk("alu_sfu.buf_pay_1", {41'd0, buf_pay_1}, {41'd0, PB});
        next_slot();
        rs_free_1 = 3'b000;
        rs_free_2 = 3'b000;
        #1;
        chk_out("alu_sfu.empty", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

        // AGU + AGU with only one AGU slot free
        rs_free_1 = 3'b100;
        drive(2'b11, 2'b10, 2'b10, PC, PD);
        next_slot();
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        #1;
        chk_out("agu2.first", 3'b100, 3'b000, 3'b000, 1'b0, 1'b0);
        next_slot();
        chk_out("agu2.only1", 3'b100, 3'b000, 3'b100, 1'b0, 1'b1);
        next_slot();
        rs_free_1 = 3'b000;
        #1;
        chk_out("agu2.empty", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

        // Same unit with two slots free: both in one cycle via write_num
        rs_free_1 = 3'b010;
        rs_free_2 = 3'b010;
        drive(2'b11, 2'b01, 2'b01, PA, PC);
        next_slot();
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        #1;
        chk_out("sfu2", 3'b010, 3'b010, 3'b000, 1'b0, 1'b1);
        next_slot();
        rs_free_1 = 3'b000;
        rs_free_2 = 3'b000;

        // dec_valid[1] alone does not load
        drive(2'b10, 2'b00, 2'b00, PB, PB);
        next_slot();
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        rs_free_1 = 3'b111;
        #1;
        chk_out("valid1_only", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

        // ALU head stalled for five cycles
        rs_free_1 = 3'b000;
        drive(2'b01, 2'b00, 2'b11, PD, PA);
        next_slot();
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_out($sformatf("stall%0d", i), 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
            next_slot();
        end
        rs_free_1 = 3'b001;
        #1;
`ifdef RS_DISPATCH_PERF_EN
        chk("stall.stall_cycles", {112'd0, stall_cycles}, 128'd5);
        chk("stall.disp_count",   {112'd0, disp_count},   128'd6);
`endif
        chk_out("stall.release", 3'b001, 3'b000, 3'b000, 1'b0, 1'b1);
        next_slot();

        // Illegal head plus ALU
        drive(2'b11, 2'b11, 2'b00, PB, PC);
        next_slot();
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        #1;
        chk_out("ill_alu", 3'b001, 3'b000, 3'b001, 1'b1, 1'b1);
        next_slot();
        rs_free_1 = 3'b000;
        #1;
        chk_out("ill_alu.empty", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

        // Flush in BOTH while a new pair is offered
        drive(2'b11, 2'b00, 2'b01, PA, PB);
        next_slot();
        flush     = 1'b1;
        rs_free_1 = 3'b111;
        rs_free_2 = 3'b111;
        drive(2'b11, 2'b10, 2'b10, PC, PD);
        #1;
        chk_out("flush", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        next_slot();
        flush = 1'b0;
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        #1;
        chk_out("flush.after", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

        // Reset asserted mid-cycle in ONLY1
        rs_free_1 = 3'b100;
        rs_free_2 = 3'b000;
        drive(2'b11, 2'b10, 2'b10, PC, PD);
        next_slot();
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        next_slot();
        chk_out("rst.only1", 3'b100, 3'b000, 3'b100, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk_out("rst.async", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        chk("rst.buf_pay_0", {41'd0, buf_pay_0}, 128'd0);
`ifdef RS_DISPATCH_PERF_EN
        chk("rst.disp_count", {112'd0, disp_count}, 128'd0);
`endif
        next_slot();
        reset     = 1'b0;
        rs_free_1 = 3'b111;
        rs_free_2 = 3'b111;
        next_slot();
        chk_out("rst.after", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
